// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Drives the common data bus (CDB) listened to by the reservation stations,
// the ROB and the PRF. Each functional unit (0=arith, 1=br, 2=lsq, 3=mult)
// deposits completed results into its own small FIFO; one FIFO head per cycle
// is picked round-robin and broadcast from a registered CDB stage.
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   flush       mispredict flush; drops buffered and outgoing results
//   src_valid   per-source result present
//   src_ready   per-source FIFO has room (from registered count only)
//   src_pd/rd/data/rob   per-source payload, packed slice i per source
//   src_sent    one-hot pulse: head of source i granted this cycle
//   cdb_valid   registered broadcast valid (one cycle per grant)
//   cdb_pd/rd/data/rob   registered broadcast payload (holds when idle)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int PREG_W     = 6,
  parameter int AREG_W     = 5,
  parameter int ROB_W      = 5,
  parameter int DATA_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC*PREG_W-1:0]   src_pd,
  input  logic [NUM_SRC*AREG_W-1:0]   src_rd,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC*ROB_W-1:0]    src_rob,
  output logic [NUM_SRC-1:0]          src_sent,
  output logic                        cdb_valid,
  output logic [PREG_W-1:0]           cdb_pd,
  output logic [AREG_W-1:0]           cdb_rd,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [ROB_W-1:0]            cdb_rob
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [PREG_W-1:0] pd;
    logic [AREG_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob;
  } entry_t;

  entry_t        mem_q    [NUM_SRC][FIFO_DEPTH];
  entry_t        mem_d    [NUM_SRC][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [NUM_SRC];
  logic [PW-1:0] wr_ptr_d [NUM_SRC];
  logic [PW-1:0] rd_ptr_q [NUM_SRC];
  logic [PW-1:0] rd_ptr_d [NUM_SRC];
  logic [CW-1:0] count_q  [NUM_SRC];
  logic [CW-1:0] count_d  [NUM_SRC];
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  entry_t        cdb_q, cdb_d;
  logic          cdb_valid_q, cdb_valid_d;

  logic               grant_valid;
  logic [SW-1:0]      grant_idx;
  logic [SW-1:0]      scan_idx;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;

  // Ready looks only at the registered count, so a pop in the same cycle
  // never opens a slot early; this keeps ready free of the arbiter path.
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (count_q[i] != CW'(FIFO_DEPTH));
    end
  end

  // Round-robin pick: scan upward from rr_ptr, wrapping, and take the first
  // non-empty FIFO. Only registered counts are used, so a result pushed this
  // cycle cannot be granted until the next one.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = SW'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!grant_valid && (count_q[scan_idx] != '0)) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Flush suppresses both the accept and the grant of this cycle, which also
  // forces the sent pulses low so no source advances on a dropped result.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      push[i] = src_valid[i] && src_ready[i] && !flush;
      pop[i]  = grant_valid && (grant_idx == SW'(i)) && !flush;
    end
  end

  assign src_sent = pop;

  // Next-state for the FIFOs, the round-robin pointer and the CDB stage.
  // Flush empties every FIFO but deliberately leaves rr_ptr where it was.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_d       = cdb_q;
    cdb_valid_d = 1'b0;

    if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        count_d[i]  = '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) begin
          mem_d[i][wr_ptr_q[i]].pd   = src_pd[i*PREG_W +: PREG_W];
          mem_d[i][wr_ptr_q[i]].rd   = src_rd[i*AREG_W +: AREG_W];
          mem_d[i][wr_ptr_q[i]].data = src_data[i*DATA_W +: DATA_W];
          mem_d[i][wr_ptr_q[i]].rob  = src_rob[i*ROB_W +: ROB_W];
          wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
        end
        if (pop[i]) begin
          rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
        end
        if (push[i] && !pop[i]) begin
          count_d[i] = count_q[i] + CW'(1);
        end else if (pop[i] && !push[i]) begin
          count_d[i] = count_q[i] - CW'(1);
        end
      end
      if (grant_valid) begin
        cdb_d       = mem_q[grant_idx][rd_ptr_q[grant_idx]];
        cdb_valid_d = 1'b1;
        rr_ptr_d    = SW'((int'(grant_idx) + 1) % NUM_SRC);
      end
    end
  end

  // Control state and the CDB stage; reset clears everything including the
  // payload and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_ptr_q    <= '0;
      cdb_q       <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_q       <= cdb_d;
      cdb_valid_q <= cdb_valid_d;
    end
  end

  // FIFO storage needs no reset: an entry is only read once its count says
  // it was written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_pd    = cdb_q.pd;
  assign cdb_rd    = cdb_q.rd;
  assign cdb_data  = cdb_q.data;
  assign cdb_rob   = cdb_q.rob;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter. Each cycle starts 1 time unit after the
// rising edge: inputs are driven, then outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int NS = 4;
  localparam int PW = 6;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [NS-1:0]    src_valid;
  logic [NS-1:0]    src_ready;
  logic [NS*PW-1:0] src_pd;
  logic [NS*AW-1:0] src_rd;
  logic [NS*DW-1:0] src_data;
  logic [NS*RW-1:0] src_rob;
  logic [NS-1:0]    src_sent;
  logic             cdb_valid;
  logic [PW-1:0]    cdb_pd;
  logic [AW-1:0]    cdb_rd;
  logic [DW-1:0]    cdb_data;
  logic [RW-1:0]    cdb_rob;

  int total = 0;
  int bad   = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_pd(src_pd), .src_rd(src_rd), .src_data(src_data), .src_rob(src_rob),
    .src_sent(src_sent),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_rd(cdb_rd),
    .cdb_data(cdb_data), .cdb_rob(cdb_rob)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    src_valid = '0;
    src_pd    = '0;
    src_rd    = '0;
    src_data  = '0;
    src_rob   = '0;
  endtask

  task automatic drive(input int i, input logic [PW-1:0] pd, input logic [AW-1:0] rd,
                       input logic [DW-1:0] data, input logic [RW-1:0] rob);
    src_valid[i]         = 1'b1;
    src_pd[i*PW +: PW]   = pd;
    src_rd[i*AW +: AW]   = rd;
    src_data[i*DW +: DW] = data;
    src_rob[i*RW +: RW]  = rob;
  endtask

  // Reset held two cycles: idle bus, all sources ready, cleared payload.
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; clear_in();
    tick(); tick();
    rst = 1'b0;
    settle();
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0b want 0", cdb_valid); end
    total++; if (src_ready !== 4'b1111) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1111", src_ready); end
    total++; if (src_sent !== 4'b0000) begin bad++; $display("[TB] FAIL reset_sent: got %b want 0000", src_sent); end
    total++; if (cdb_pd !== 6'd0 || cdb_data !== 32'd0 || cdb_rob !== 5'd0) begin bad++; $display("[TB] FAIL reset_payload: got pd=%0d data=%h rob=%0d want 0", cdb_pd, cdb_data, cdb_rob); end
  endtask

  // One arith result: sent at cycle 1, on the bus at cycle 2, payload holds after.
  task automatic test_single();
    tick(); drive(0, 6'd5, 5'd1, 32'hDEADBEEF, 5'd3); settle();
    tick(); clear_in(); settle();
    total++; if (src_sent !== 4'b0001) begin bad++; $display("[TB] FAIL single_sent: got %b want 0001", src_sent); end
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_early: got %0b want 0", cdb_valid); end
    tick(); settle();
    total++; if (cdb_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid: got %0b want 1", cdb_valid); end
    total++; if (cdb_pd !== 6'd5 || cdb_data !== 32'hDEADBEEF || cdb_rob !== 5'd3 || cdb_rd !== 5'd1) begin bad++; $display("[TB] FAIL single_payload: got pd=%0d rd=%0d data=%h rob=%0d want 5/1/deadbeef/3", cdb_pd, cdb_rd, cdb_data, cdb_rob); end
    total++; if (src_sent !== 4'b0000) begin bad++; $display("[TB] FAIL single_sent_after: got %b want 0000", src_sent); end
    tick(); settle();
    total++; if (cdb_valid !== 1'b0 || cdb_pd !== 6'd5) begin bad++; $display("[TB] FAIL single_hold: got valid=%0b pd=%0d want 0/5", cdb_valid, cdb_pd); end
  endtask

  // All four push with rr_ptr=0 -> 0,1,2,3; then rr_ptr=2 -> 2,3,0,1.
  task automatic test_round_robin();
    int ord[4];
    ord = '{2, 3, 0, 1};
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NS; i++) drive(i, PW'(10 + i), AW'(i), DW'(32'h100 + i), RW'(i));
    settle();
    for (int k = 1; k <= 4; k++) begin
      tick(); clear_in(); settle();
      total++; if (src_sent !== 4'(1 << (k - 1))) begin bad++; $display("[TB] FAIL rr1_sent%0d: got %b want %b", k, src_sent, 4'(1 << (k - 1))); end
      if (k >= 2) begin
        total++; if (cdb_valid !== 1'b1 || cdb_pd !== PW'(10 + k - 2)) begin bad++; $display("[TB] FAIL rr1_pd%0d: got v=%0b pd=%0d want 1/%0d", k, cdb_valid, cdb_pd, 10 + k - 2); end
      end
    end
    tick(); settle();
    total++; if (src_sent !== 4'b0000 || cdb_valid !== 1'b1 || cdb_pd !== 6'd13) begin bad++; $display("[TB] FAIL rr1_last: got sent=%b v=%0b pd=%0d want 0000/1/13", src_sent, cdb_valid, cdb_pd); end
    // Grant source 1 alone to move rr_ptr to 2; the batch arrives meanwhile.
    drive(1, 6'd20, 5'd1, 32'h200, 5'd9);
    tick(); clear_in();
    for (int i = 0; i < NS; i++) drive(i, PW'(30 + i), AW'(i), DW'(32'h300 + i), RW'(i));
    settle();
    total++; if (src_sent !== 4'b0010) begin bad++; $display("[TB] FAIL rr2_pre: got %b want 0010", src_sent); end
    for (int j = 0; j < 4; j++) begin
      tick(); clear_in(); settle();
      total++; if (src_sent !== 4'(1 << ord[j])) begin bad++; $display("[TB] FAIL rr2_sent%0d: got %b want %b", j, src_sent, 4'(1 << ord[j])); end
      total++; if (cdb_pd !== ((j == 0) ? 6'd20 : PW'(30 + ord[j - ((j == 0) ? 0 : 1)]))) begin bad++; $display("[TB] FAIL rr2_pd%0d: got %0d", j, cdb_pd); end
    end
    tick(); settle();
    total++; if (cdb_valid !== 1'b1 || cdb_pd !== 6'd31) begin bad++; $display("[TB] FAIL rr2_last: got v=%0b pd=%0d want 1/31", cdb_valid, cdb_pd); end
    tick(); settle();
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL rr2_idle: got %0b want 0", cdb_valid); end
  endtask

  // All four push every cycle; scoreboard per source (rd carries source id).
  task automatic test_backpressure();
    logic [DW-1:0] exp_q [NS][$];
    int seq [NS];
    int r;
    bit saw_full;
    logic [DW-1:0] e;
    saw_full = 1'b0;
    for (int i = 0; i < NS; i++) seq[i] = 0;
    for (int c = 0; c < 32; c++) begin
      tick(); clear_in();
      if (c < 20) begin
        for (int i = 0; i < NS; i++) drive(i, PW'(i + 1), AW'(i), DW'((i << 16) | seq[i]), RW'(seq[i]));
      end
      settle();
      if (cdb_valid === 1'b1) begin
        r = int'(cdb_rd);
        total++;
        if (r >= NS || exp_q[r % NS].size() == 0) begin
          bad++; $display("[TB] FAIL bp_extra: got rd=%0d data=%h want no broadcast", cdb_rd, cdb_data);
        end else begin
          e = exp_q[r].pop_front();
          if (cdb_data !== e) begin bad++; $display("[TB] FAIL bp_order: got %h want %h", cdb_data, e); end
        end
      end
      if (src_ready[3] === 1'b0) saw_full = 1'b1;
      for (int i = 0; i < NS; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          exp_q[i].push_back(DW'((i << 16) | seq[i]));
          seq[i]++;
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      total++; if (exp_q[i].size() != 0) begin bad++; $display("[TB] FAIL bp_lost%0d: got %0d left want 0", i, exp_q[i].size()); end
    end
    total++; if (!saw_full) begin bad++; $display("[TB] FAIL bp_full: got ready3 never low want low"); end
  endtask

  // Three sources busy, flush at cycle 5; a push at cycle 6 appears at cycle 8.
  task automatic test_flush();
    for (int c = 0; c < 5; c++) begin
      tick(); clear_in();
      for (int i = 0; i < 3; i++) drive(i, PW'(50 + i), AW'(i), DW'(32'h500 + c), RW'(c));
      settle();
    end
    tick(); clear_in(); flush = 1'b1; settle();
    total++; if (src_sent !== 4'b0000) begin bad++; $display("[TB] FAIL flush_sent: got %b want 0000", src_sent); end
    tick(); flush = 1'b0; drive(3, 6'd44, 5'd3, 32'hCAFE, 5'd7); settle();
    total++; if (cdb_valid !== 1'b0 || src_ready !== 4'b1111 || src_sent !== 4'b0000) begin bad++; $display("[TB] FAIL flush_c6: got v=%0b ready=%b sent=%b want 0/1111/0000", cdb_valid, src_ready, src_sent); end
    tick(); clear_in(); settle();
    total++; if (src_sent !== 4'b1000 || cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_c7: got sent=%b v=%0b want 1000/0", src_sent, cdb_valid); end
    tick(); settle();
    total++; if (cdb_valid !== 1'b1 || cdb_pd !== 6'd44 || cdb_data !== 32'hCAFE) begin bad++; $display("[TB] FAIL flush_c8: got v=%0b pd=%0d data=%h want 1/44/cafe", cdb_valid, cdb_pd, cdb_data); end
    tick(); settle();
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_c9: got %0b want 0", cdb_valid); end
  endtask

  // pd=0 is broadcast; lsq streams so push and pop coincide across pointer wrap.
  task automatic test_pd0_stream();
    tick(); drive(1, 6'd0, 5'd1, 32'h55, 5'd2); settle();
    tick(); clear_in(); settle();
    total++; if (src_sent !== 4'b0010) begin bad++; $display("[TB] FAIL pd0_sent: got %b want 0010", src_sent); end
    tick(); settle();
    total++; if (cdb_valid !== 1'b1 || cdb_pd !== 6'd0 || cdb_data !== 32'h55) begin bad++; $display("[TB] FAIL pd0_bcast: got v=%0b pd=%0d data=%h want 1/0/55", cdb_valid, cdb_pd, cdb_data); end
    for (int c = 0; c <= 6; c++) begin
      tick(); clear_in();
      if (c < 5) drive(2, PW'(40 + c), 5'd2, DW'(32'hA000 + c), RW'(c));
      settle();
      if (c >= 1 && c <= 5) begin
        total++; if (src_sent !== 4'b0100 || src_ready[2] !== 1'b1) begin bad++; $display("[TB] FAIL stream_sent%0d: got sent=%b ready2=%0b want 0100/1", c, src_sent, src_ready[2]); end
      end
      if (c >= 2) begin
        total++; if (cdb_valid !== 1'b1 || cdb_data !== DW'(32'hA000 + c - 2)) begin bad++; $display("[TB] FAIL stream_data%0d: got v=%0b data=%h want 1/%h", c, cdb_valid, cdb_data, 32'hA000 + c - 2); end
      end
    end
    tick(); settle();
    total++; if (cdb_valid !== 1'b0 || src_sent !== 4'b0000) begin bad++; $display("[TB] FAIL stream_end: got v=%0b sent=%b want 0/0000", cdb_valid, src_sent); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_pd0_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
